instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 SHALL have ports: in_valid in 1 request valid; in_ready out 1 accept.
REQ-003 SHALL have ports: fmt in 3 format (R=0,I=1,S=2,B=3,U=4,J=5); opcode in 7; rd, rs1, rs2 in 5 each; funct3 in 3; funct7 in 7; imm in 32 signed immediate.
REQ-004 SHALL have ports: out_valid out 1; out_ready in 1; instr out 32 encoded RV32 word; err out 1 encode error.
REQ-005 SHALL have ports: instr_cnt out 16 accepted-request count; err_cnt out 8 error count.
REQ-006 One clock; reset is asynchronous and active-low.

Function
REQ-007 SHALL accept a request on a cycle with in_valid && in_ready.
REQ-008 in_ready SHALL equal !out_valid || out_ready (single output register, full throughput).
REQ-009 Result SHALL appear in the output register on the edge after acceptance (latency 1).
REQ-010 instr, err SHALL hold stable while out_valid && !out_ready.
REQ-011 out_valid SHALL clear on out_ready handshake unless a new request is accepted in the same cycle, in which case it stays 1 with new data.
REQ-012 Packing: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-013 Packing: B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-014 imm SHALL be ignored for R; fields unused by a format SHALL be ignored.
REQ-015 fmt 6 or 7 SHALL produce instr=0, err=1.
REQ-016 instr_cnt SHALL increment on every acceptance, wrapping 0xFFFF->0.
REQ-017 err_cnt SHALL increment when an accepted request yields err=1, saturating at 0xFF.
REQ-018 Simultaneous output drain and new accept SHALL lose no request and double-count nothing.

Reset
REQ-019 On rst_n low, asynchronously: out_valid=0, instr=0, err=0, instr_cnt=0, err_cnt=0.
REQ-020 Reset mid-handshake SHALL discard the held result; first post-reset request SHALL be accepted normally.
REQ-021 in_ready SHALL be 1 during and after reset (out_valid=0).

Configuration
REQ-022 Macro IMM_RANGE_CHECK_EN defined: err=1 when I/S imm outside [-2048,2047]; B outside [-4096,4094] or imm[0]=1; J outside [-1048576,1048574] or imm[0]=1; U imm[11:0]!=0; instr still packed from truncated bits.
REQ-023 Macro not defined: err set only per REQ-015; immediates silently truncated.

Structure
REQ-024 Shared package SHALL hold the fmt encodings and standard opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR).
REQ-025 Combinational packing and range check SHALL live in sub-module imm_pack; instr_encoder holds handshake register and counters.

Verification
REQ-026 I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> instr=0x00500093, err=0, one cycle after accept.
REQ-027 B, opcode=0x63, rs1=rs2=0, funct3=0, imm=-4 -> instr=0xFE000EE3, err=0.
REQ-028 J, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF; U, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-029 With IMM_RANGE_CHECK_EN, I imm=2048 -> err=1, err_cnt 0->1; B imm=3 -> err=1; fmt=7 -> instr=0, err=1 in both builds.
REQ-030 out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0, instr stable; release -> back-to-back accepts, instr_cnt exact, no drop.
REQ-031 Assert rst_n low while out_valid=1 -> out_valid, counters 0 immediately; 300 errors -> err_cnt=0xFF; 65536 accepts -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared definitions for the RV32 instruction encoder.
//   - fmt_e      : encoding of the fmt request field (values 6 and 7 are illegal)
//   - OPC_*      : standard RV32I major opcodes
//   - IMM_* / J_*: legal signed immediate ranges used when IMM_RANGE_CHECK_EN is defined
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
    localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: combinational RV32 field packer.
// Ports:
//   fmt    in  3   format select (R/I/S/B/U/J = 0..5, 6/7 illegal)
//   opcode in  7   major opcode
//   rd, rs1, rs2 in 5  register indices
//   funct3 in  3, funct7 in 7
//   imm    in  32  signed immediate
//   instr  out 32  packed instruction word
//   err    out 1   encode error
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not
// fit their format; the word is still packed from the truncated bits.
module imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]         fmt,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic signed [31:0] imm,
    output logic [31:0]        instr,
    output logic               err
);

    always_comb begin
        instr = '0;
        err   = 1'b0;
        case (fmt)
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                err = (imm < IMM12_MIN) || (imm > IMM12_MAX);
`endif
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef IMM_RANGE_CHECK_EN
                err = (imm < IMM12_MIN) || (imm > IMM12_MAX);
`endif
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef IMM_RANGE_CHECK_EN
                // Branch offsets are halfword aligned, so bit 0 must be clear.
                err = (imm < IMMB_MIN) || (imm > IMMB_MAX) || imm[0];
`endif
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                err = (imm[11:0] != 12'd0);
`endif
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                err = (imm < IMMJ_MIN) || (imm > IMMJ_MAX) || imm[0];
`endif
            end
            default: begin
                instr = '0;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32 instruction encoder with a single valid/ready output
// register (latency 1, full throughput) plus request and error counters.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         request handshake
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm   request fields
//   out_valid / out_ready       result handshake
//   instr, err                  registered encoded word and error flag
//   instr_cnt                   accepted requests, wraps at 16 bits
//   err_cnt                     accepted requests with err=1, saturates at 0xFF
// Optional feature: IMM_RANGE_CHECK_EN (see imm_pack) enables immediate range errors.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         fmt,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic signed [31:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        instr,
    output logic               err,
    output logic [15:0]        instr_cnt,
    output logic [7:0]         err_cnt
);

    logic [31:0] instr_p0;
    logic        err_p0;
    logic        accept;

    // Stage 0: combinational packing of the incoming request
    imm_pack u_imm_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .instr  (instr_p0),
        .err    (err_p0)
    );

    // The register can take a new word whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage 1: output register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= '0;
            err       <= 1'b0;
            instr_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                instr     <= instr_p0;
                err       <= err_p0;
                instr_cnt <= instr_cnt + 16'd1;
                if (err_p0 && (err_cnt != 8'hFF))
                    err_cnt <= err_cnt + 8'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
